// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 sequencer/decoder.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH,
        S_FETCH_MEM,
        S_FETCH_IR,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_LEA,
        S_BR_TAKEN,
        S_JMP,
        S_JSR_LINK,
        S_JSR_PC,
        S_ADDR_PC,
        S_ADDR_BASE,
        S_IND_MEM,
        S_IND_MAR,
        S_RD_MEM,
        S_WB,
        S_ST_DATA,
        S_WR_MEM,
        S_PAUSE1,
        S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_RTI   = 4'b1000;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_LDI   = 4'b1010;
    localparam logic [3:0] OP_STI   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;
    localparam logic [3:0] OP_TRAP  = 4'b1111;

    localparam logic [1:0] PCMUX_BUS   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b01;
    localparam logic [1:0] PCMUX_INC   = 2'b10;

    localparam logic [1:0] ADDR2_OFF11 = 2'b00;
    localparam logic [1:0] ADDR2_OFF9  = 2'b01;
    localparam logic [1:0] ADDR2_OFF6  = 2'b10;
    localparam logic [1:0] ADDR2_ZERO  = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_PASSA = 2'b10;
    localparam logic [1:0] ALUK_NOT   = 2'b11;

endpackage

// File: rtl/lc3_wait_ctr.sv
// Memory wait-state counter: cleared outside an access, counts cycles inside one.
module lc3_wait_ctr #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic done
);
    localparam int           W    = $clog2(MEM_WAIT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_WAIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear has priority so a finishing access leaves the counter at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + W'(1);
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/lc3_isdu_ws.sv
// LC-3 instruction sequencer/decoder with configurable SRAM wait states.
//
// state       | meaning
// HALTED      | idle after reset, waits for Run
// FETCH       | MAR <- PC, PC <- PC+1
// FETCH_MEM   | instruction read strobe, MDR loaded on last cycle
// FETCH_IR    | IR <- MDR
// DECODE      | BEN load, dispatch on opcode, Illegal on unsupported opcode
// ADD/AND/NOT | ALU op written back with CC
// LEA         | DR <- PC+off9
// BR_TAKEN    | PC <- PC+off9
// JMP         | PC <- BaseR
// JSR_LINK    | R7 <- PC
// JSR_PC      | PC <- PC+off11 (JSR) or BaseR (JSRR)
// ADDR_PC     | MAR <- PC+off9 (LD/LDI/ST/STI)
// ADDR_BASE   | MAR <- BaseR+off6 (LDR/STR)
// IND_MEM     | pointer read for LDI/STI
// IND_MAR     | MAR <- MDR
// RD_MEM      | data read
// WB          | DR <- MDR with CC
// ST_DATA     | MDR <- SR
// WR_MEM      | data write strobe
// PAUSE1/2    | LED load, Continue high then low handshake
module lc3_isdu_ws
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT    = 2,
    parameter int EN_INDIRECT = 1,
    parameter int EN_PAUSE    = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       Illegal
);

    if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_bad_mem_wait
        $error("lc3_isdu_ws: MEM_WAIT must be in 1..15");
    end

    state_t state_q, state_d;
    state_t decode_next;
    logic   op_legal;
    logic   in_mem;
    logic   wait_done;

    assign in_mem = (state_q == S_FETCH_MEM) || (state_q == S_IND_MEM) ||
                    (state_q == S_RD_MEM)    || (state_q == S_WR_MEM);

    lc3_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk   (Clk),
        .reset (Reset),
        .clr   (!in_mem || wait_done),
        .inc   (in_mem),
        .done  (wait_done)
    );

    // Opcode dispatch target and legality, used only while in DECODE.
    always_comb begin
        decode_next = S_FETCH;
        op_legal    = 1'b1;
        case (Opcode)
            OP_ADD:   decode_next = S_ADD;
            OP_AND:   decode_next = S_AND;
            OP_NOT:   decode_next = S_NOT;
            OP_LEA:   decode_next = S_LEA;
            OP_BR:    decode_next = BEN ? S_BR_TAKEN : S_FETCH;
            OP_JMP:   decode_next = S_JMP;
            OP_JSR:   decode_next = S_JSR_LINK;
            OP_LD,
            OP_ST:    decode_next = S_ADDR_PC;
            OP_LDR,
            OP_STR:   decode_next = S_ADDR_BASE;
            OP_LDI,
            OP_STI: begin
                if (EN_INDIRECT != 0) decode_next = S_ADDR_PC;
                else                  op_legal    = 1'b0;
            end
            OP_PAUSE: begin
                if (EN_PAUSE != 0) decode_next = S_PAUSE1;
                else               op_legal    = 1'b0;
            end
            default:  op_legal = 1'b0;
        endcase
    end

    // Next-state logic. IR stays stable after FETCH_IR, so later states may steer on Opcode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALTED:    if (Run) state_d = S_FETCH;
            S_FETCH:     state_d = S_FETCH_MEM;
            S_FETCH_MEM: if (wait_done) state_d = S_FETCH_IR;
            S_FETCH_IR:  state_d = S_DECODE;
            S_DECODE:    state_d = decode_next;
            S_JSR_LINK:  state_d = S_JSR_PC;
            S_ADDR_PC,
            S_ADDR_BASE: begin
                if (Opcode == OP_LDI || Opcode == OP_STI)
                    state_d = S_IND_MEM;
                else if (Opcode == OP_ST || Opcode == OP_STR)
                    state_d = S_ST_DATA;
                else
                    state_d = S_RD_MEM;
            end
            S_IND_MEM:   if (wait_done) state_d = S_IND_MAR;
            S_IND_MAR:   state_d = (Opcode == OP_LDI) ? S_RD_MEM : S_ST_DATA;
            S_RD_MEM:    if (wait_done) state_d = S_WB;
            S_ST_DATA:   state_d = S_WR_MEM;
            S_WR_MEM:    if (wait_done) state_d = S_FETCH;
            S_PAUSE1:    if (Continue) state_d = S_PAUSE2;
            S_PAUSE2:    if (!Continue) state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // State register; reset wins even in the middle of a memory access.
    always_ff @(posedge Clk) begin
        if (Reset)
            state_q <= S_HALTED;
        else
            state_q <= state_d;
    end

    assign Mem_CE = 1'b0;
    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

    // Moore control decode; BaseR is IR[8:6], hence SR1MUX=1 wherever a base register is read.
    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = PCMUX_BUS; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
        ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF11; ALUK = ALUK_ADD;
        Mem_OE = 1'b1; Mem_WE = 1'b1; Illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_INC;
            end
            S_FETCH_MEM, S_IND_MEM, S_RD_MEM: begin
                Mem_OE = 1'b0; LD_MDR = wait_done;
            end
            S_FETCH_IR: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
            end
            S_DECODE: begin
                LD_BEN = 1'b1; Illegal = !op_legal;
            end
            S_ADD, S_AND: begin
                SR1MUX = 1'b1; SR2MUX = IR_5;
                ALUK = (state_q == S_AND) ? ALUK_AND : ALUK_ADD;
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            end
            S_NOT: begin
                SR1MUX = 1'b1; ALUK = ALUK_NOT; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            end
            S_LEA: begin
                ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF9; GateMARMUX = 1'b1;
                LD_REG = 1'b1; LD_CC = 1'b1;
            end
            S_BR_TAKEN: begin
                LD_PC = 1'b1; PCMUX = PCMUX_ADDER; ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF9;
            end
            S_JMP: begin
                SR1MUX = 1'b1; ALUK = ALUK_PASSA; GateALU = 1'b1; PCMUX = PCMUX_BUS; LD_PC = 1'b1;
            end
            S_JSR_LINK: begin
                GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
            end
            S_JSR_PC: begin
                LD_PC = 1'b1; PCMUX = PCMUX_ADDER;
                if (IR_11) begin
                    ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF11;
                end else begin
                    ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_ZERO; SR1MUX = 1'b1;
                end
            end
            S_ADDR_PC: begin
                ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF9; GateMARMUX = 1'b1; LD_MAR = 1'b1;
            end
            S_ADDR_BASE: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF6;
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
            end
            S_IND_MAR: begin
                GateMDR = 1'b1; LD_MAR = 1'b1;
            end
            S_WB: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            end
            S_ST_DATA: begin
                SR1MUX = 1'b0; ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1;
            end
            S_WR_MEM: begin
                Mem_WE = 1'b0;
            end
            S_PAUSE1: begin
                LD_LED = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
